iir_out_decimator: RTL

Downstream stage of the 16-bit IIR filter; consumes `y_val` every clock it is enabled. Discards the filter's start-up transient, then averages each group of `DECIM` consecutive samples with rounding. Buffers the results in a small FIFO and presents them on a valid/ready stream. Raises a sticky flag when results are lost to back-pressure.

---
 rtl/iir_pkg.sv | 23 ++
 rtl/iir_out_decimator_if.sv | 17 +
 rtl/iir_sync_fifo.sv | 59 +++++
 rtl/iir_out_decimator.sv | 121 ++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter chain: sample type, FSM encoding and
// a constant-foldable ceil(log2) helper.
package iir_pkg;

    localparam int IIR_DATA_W = 16;

    typedef logic signed [IIR_DATA_W-1:0] iir_sample_t;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_ACC  = 1'b1
    } dec_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_out_decimator_if.sv
// Result stream from the decimator to its consumer.
interface iir_out_decimator_if
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W
);

    // A beat transfers on a rising edge where m_valid & m_ready are both 1;
    // the producer drives m_valid/m_data from registers, never from m_ready.
    logic signed [DATA_W-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/iir_sync_fifo.sv
// Count-based synchronous FIFO with a registered head that holds its last
// value when the FIFO drains.
module iir_sync_fifo
    import iir_pkg::*;
#(
    parameter int WIDTH = IIR_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // The head register looks ahead so the new head is visible the cycle
    // after a pop, bypassing storage when the written entry becomes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                head <= (do_push && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/iir_out_decimator.sv
// Drops the filter start-up transient, averages groups of DECIM samples with
// round-half-up, and buffers results onto a valid/ready stream.
module iir_out_decimator
    import iir_pkg::*;
#(
    parameter int DATA_W     = IIR_DATA_W,
    parameter int DECIM      = 4,
    parameter int WARMUP     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] y_val,
    input  logic                     en,
    iir_out_decimator_if.master      m,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output dec_state_t               dbg_state
);

    localparam int LOG2D = clog2(DECIM);
    localparam int ACC_W = DATA_W + LOG2D + 1;
    localparam int PW    = (LOG2D < 1) ? 1 : LOG2D;
    localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
    localparam dec_state_t RST_STATE = (WARMUP == 0) ? ST_ACC : ST_WARM;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(DECIM / 2);

    dec_state_t               state_q, state_d;
    logic [7:0]               warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]            phase_q, phase_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  y_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     res_valid;
    logic signed [DATA_W-1:0] res_data;
    logic [DATA_W-1:0]        head;
    logic                     full;
    logic                     empty;
    logic                     drop;

    assign y_ext    = {{(LOG2D + 1){y_val[DATA_W-1]}}, y_val};
    assign acc_sum  = acc_q + y_ext + HALF;
    // The sum of DECIM in-range samples shifted by log2(DECIM) always fits DATA_W.
    assign res_data = DATA_W'(acc_sum >>> LOG2D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            warm_cnt_q <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        phase_d    = phase_q;
        acc_d      = acc_q;
        res_valid  = 1'b0;
        if (en) begin
            case (state_q)
                ST_WARM: begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d    = ST_ACC;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                    end
                end
                ST_ACC: begin
                    acc_d = (phase_q == '0) ? y_ext : acc_q + y_ext;
                    if (phase_q == PW'(DECIM - 1)) begin
                        res_valid = 1'b1;
                        phase_d   = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    iir_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (res_valid),
        .wr_data (res_data),
        .pop     (m.m_ready),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    assign m.m_data  = head;
    assign m.m_valid = !empty;
    assign dbg_state = state_q;

    // A full FIFO still accepts a result when the consumer pops in the same cycle.
    assign drop = res_valid && full && !m.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
